// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared state/op types and the memory-mapped I/O address for the LC-3 memory responder
package lc3_mem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;
   typedef enum logic {OP_READ, OP_WRITE} op_t;
   localparam logic [15:0] IO_ADDR = 16'hFFFF;
endpackage

// File: rtl/lc3_mem_responder_sram_1p.sv
// sram_1p: single-port RAM with clocked write and combinational read
module sram_1p #(
   parameter int DEPTH = 1024
) (
   input  logic                     Clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [15:0]              wdata,
   output logic [15:0]              rdata
);
   logic [15:0] mem [DEPTH];
   // store on the edge; the read side is combinational so the access edge sees current contents
   always_ff @(posedge Clk)
      if (we) mem[addr] <= wdata;
   assign rdata = mem[addr];
endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: MAR/MDR memory responder with access latency, I/O decode at IO_ADDR and a loader port
module lc3_mem_responder
   import lc3_mem_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MEM_OE,
   input  logic        MEM_WE,
   input  logic [15:0] ADDR,
   input  logic [15:0] Data_from_CPU,
   output logic [15:0] Data_to_CPU,
   output logic        R,
   input  logic [15:0] SW,
   output logic [15:0] HEX_Out,
   input  logic        LD_EN,
   input  logic [15:0] LD_ADDR,
   input  logic [15:0] LD_DATA
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(WAIT_CYCLES + 1);
   state_t      state;
   op_t         lat_op;
   logic [CW-1:0] cnt;
   logic [15:0] lat_addr, lat_data, rdata;
   logic        req, ld, fire, ram_we;
   assign req    = MEM_OE | MEM_WE;
   assign ld     = state == IDLE && LD_EN;
   assign fire   = state == WAIT && req && cnt == '0;
   assign ram_we = !Reset && (ld || (fire && lat_op == OP_WRITE && lat_addr != IO_ADDR));
   // the loader owns the RAM port only while idle; otherwise the latched request drives it
   sram_1p #(.DEPTH(DEPTH)) u_ram (
      .Clk   (Clk),
      .we    (ram_we),
      .addr  (AW'(ld ? LD_ADDR : lat_addr)),
      .wdata (ld ? LD_DATA : lat_data),
      .rdata (rdata)
   );
   // request FSM: latch on acceptance, count down latency, access and pulse R, then wait for release
   always_ff @(posedge Clk)
      if (Reset) begin
         state       <= IDLE;
         cnt         <= '0;
         R           <= 1'b0;
         Data_to_CPU <= 16'h0000;
         HEX_Out     <= 16'h0000;
      end else begin
         R <= 1'b0;
         case (state)
            IDLE: if (req) begin
               lat_addr <= ADDR;
               lat_data <= Data_from_CPU;
               lat_op   <= MEM_WE ? OP_WRITE : OP_READ;
               cnt      <= CW'(WAIT_CYCLES - 1);
               state    <= WAIT;
            end
            WAIT: if (!req) state <= IDLE;
            else if (fire) begin
               state <= DONE;
               R     <= 1'b1;
               if (lat_op == OP_WRITE) begin
                  if (lat_addr == IO_ADDR) HEX_Out <= lat_data;
               end else Data_to_CPU <= lat_addr == IO_ADDR ? SW : rdata;
            end else cnt <= cnt - 1'b1;
            DONE: state <= HOLD;
            HOLD: if (!req) state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder: directed checks of latency, RAM/I-O access, aliasing, aborts, reset and loader
module tb_lc3_mem_responder;
   logic        Clk = 0, Reset = 1, MEM_OE = 0, MEM_WE = 0, R, LD_EN = 0;
   logic [15:0] ADDR = 0, Data_from_CPU = 0, Data_to_CPU, SW = 0, HEX_Out, LD_ADDR = 0, LD_DATA = 0;
   int total = 0, bad = 0;

   lc3_mem_responder dut (
      .Clk(Clk), .Reset(Reset), .MEM_OE(MEM_OE), .MEM_WE(MEM_WE), .ADDR(ADDR),
      .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .R(R), .SW(SW),
      .HEX_Out(HEX_Out), .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic load(input logic [15:0] a, input logic [15:0] d);
      LD_EN = 1; LD_ADDR = a; LD_DATA = d;
      step();
      LD_EN = 0;
   endtask

   // full handshake; ADDR/data are scrambled after acceptance to prove they were latched
   task automatic access(input logic oe, input logic we, input logic [15:0] a, input logic [15:0] d);
      int n;
      MEM_OE = oe; MEM_WE = we; ADDR = a; Data_from_CPU = d;
      step();
      n = 1;
      ADDR = ~a; Data_from_CPU = ~d;
      while (!R && n < 20) begin
         step();
         n++;
      end
      check("latency", 16'(n), 16'd3);
      MEM_OE = 0; MEM_WE = 0;
      step();
      check("r_one_cycle", {15'b0, R}, 16'h0);
      step();
   endtask

   initial begin
      int pulses;
      step(); step();
      Reset = 0;
      check("rst_r", {15'b0, R}, 16'h0);
      check("rst_data", Data_to_CPU, 16'h0000);
      check("rst_hex", HEX_Out, 16'h0000);
      for (int i = 0; i < 1024; i++) load(16'(i), 16'h0000);

      load(16'h0005, 16'h1234);
      access(1, 0, 16'h0005, 16'h0);
      check("rd_load", Data_to_CPU, 16'h1234);

      access(0, 1, 16'h0010, 16'hBEEF);
      check("wr_keeps_data", Data_to_CPU, 16'h1234);
      access(1, 0, 16'h0010, 16'h0);
      check("rd_0010", Data_to_CPU, 16'hBEEF);
      access(1, 0, 16'h0410, 16'h0);
      check("rd_alias", Data_to_CPU, 16'hBEEF);

      SW = 16'h00A5;
      access(1, 0, 16'hFFFF, 16'h0);
      check("rd_sw", Data_to_CPU, 16'h00A5);
      access(0, 1, 16'hFFFF, 16'h4321);
      check("hex", HEX_Out, 16'h4321);
      check("hex_wr_keeps_data", Data_to_CPU, 16'h00A5);
      access(1, 0, 16'h03FF, 16'h0);
      check("io_alias_untouched", Data_to_CPU, 16'h0000);
      load(16'hFFFF, 16'h5A5A);
      check("ld_io_not_hex", HEX_Out, 16'h4321);
      access(1, 0, 16'h03FF, 16'h0);
      check("ld_io_aliases_ram", Data_to_CPU, 16'h5A5A);

      access(1, 1, 16'h0050, 16'h0ABC);
      check("oe_we_is_write", Data_to_CPU, 16'h5A5A);
      access(1, 0, 16'h0050, 16'h0);
      check("oe_we_stored", Data_to_CPU, 16'h0ABC);

      MEM_OE = 1; ADDR = 16'h0010;
      pulses = 0;
      repeat (10) begin
         step();
         pulses += int'(R);
      end
      check("held_one_pulse", 16'(pulses), 16'd1);
      check("held_data", Data_to_CPU, 16'hBEEF);
      MEM_OE = 0;
      step();
      access(1, 0, 16'h0005, 16'h0);
      check("after_hold", Data_to_CPU, 16'h1234);

      MEM_WE = 1; ADDR = 16'h0020; Data_from_CPU = 16'h7777;
      step(); step();
      MEM_WE = 0;
      pulses = 0;
      repeat (5) begin
         step();
         pulses += int'(R);
      end
      check("abort_no_r", 16'(pulses), 16'd0);
      check("abort_keeps_data", Data_to_CPU, 16'h1234);
      access(1, 0, 16'h0020, 16'h0);
      check("abort_no_write", Data_to_CPU, 16'h0000);

      LD_EN = 1; LD_ADDR = 16'h0040; LD_DATA = 16'hCAFE; MEM_OE = 1; ADDR = 16'h0040;
      step();
      LD_ADDR = 16'h0041; LD_DATA = 16'h1111;
      step(); step();
      check("ld_req_r", {15'b0, R}, 16'h1);
      check("ld_req_data", Data_to_CPU, 16'hCAFE);
      LD_EN = 0; MEM_OE = 0;
      step(); step();
      access(1, 0, 16'h0041, 16'h0);
      check("ld_ignored_busy", Data_to_CPU, 16'h0000);

      MEM_WE = 1; ADDR = 16'h0030; Data_from_CPU = 16'h9999;
      step(); step();
      Reset = 1;
      step();
      check("midrst_r", {15'b0, R}, 16'h0);
      check("midrst_data", Data_to_CPU, 16'h0000);
      check("midrst_hex", HEX_Out, 16'h0000);
      Reset = 0; MEM_WE = 0;
      pulses = 0;
      repeat (4) begin
         step();
         pulses += int'(R);
      end
      check("midrst_no_r", 16'(pulses), 16'd0);
      access(1, 0, 16'h0030, 16'h0);
      check("midrst_no_write", Data_to_CPU, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
